// File: rtl/bus_pkg.sv
// bus_pkg: source codes, defaults and FSM encoding shared by the bus scheduler.
package bus_pkg;
    localparam int NSRC_DEFAULT = 25;
    localparam logic [4:0] SRC_PC    = 5'd0;
    localparam logic [4:0] SRC_IR    = 5'd1;
    localparam logic [4:0] SRC_R0    = 5'd2;
    localparam logic [4:0] SRC_R1    = 5'd3;
    localparam logic [4:0] SRC_R2    = 5'd4;
    localparam logic [4:0] SRC_R3    = 5'd5;
    localparam logic [4:0] SRC_R4    = 5'd6;
    localparam logic [4:0] SRC_R5    = 5'd7;
    localparam logic [4:0] SRC_R6    = 5'd8;
    localparam logic [4:0] SRC_R7    = 5'd9;
    localparam logic [4:0] SRC_R8    = 5'd10;
    localparam logic [4:0] SRC_R9    = 5'd11;
    localparam logic [4:0] SRC_R10   = 5'd12;
    localparam logic [4:0] SRC_R11   = 5'd13;
    localparam logic [4:0] SRC_R12   = 5'd14;
    localparam logic [4:0] SRC_R13   = 5'd15;
    localparam logic [4:0] SRC_R14   = 5'd16;
    localparam logic [4:0] SRC_R15   = 5'd17;
    localparam logic [4:0] SRC_MDR   = 5'd18;
    localparam logic [4:0] SRC_HI    = 5'd19;
    localparam logic [4:0] SRC_LO    = 5'd20;
    localparam logic [4:0] SRC_RZH   = 5'd21;
    localparam logic [4:0] SRC_RZL   = 5'd22;
    localparam logic [4:0] SRC_IP    = 5'd23;
    localparam logic [4:0] SRC_CSIGN = 5'd24;
    typedef enum logic {IDLE, LOCKED} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last,
    output logic [NREQ-1:0] grant
);
    logic hit;
    always_comb begin
        grant = '0;
        hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!hit && req[i] && i > int'(last)) begin
                grant[i] = 1'b1;
                hit = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!hit && req[i] && i <= int'(last)) begin
                grant[i] = 1'b1;
                hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_scheduler.sv
// bus_scheduler: round-robin CPU bus arbiter with bus locking and registered
// one-hot source enables for the bus mux.
module bus_scheduler
    import bus_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int NSRC     = NSRC_DEFAULT,
    parameter int SRCW     = 5,
    parameter int DSTW     = 5,
    parameter int LOCK_MAX = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*SRCW-1:0] req_src,
    input  logic [NREQ*DSTW-1:0] req_dst,
    input  logic [NREQ-1:0]      req_lock,
    output logic [NREQ-1:0]      req_ready,
    output logic [NSRC-1:0]      src_oe,
    output logic [DSTW-1:0]      dst_code,
    output logic                 dst_valid,
    output logic [2:0]           owner,
    output logic                 locked,
    output logic                 err_src,
    output logic                 lock_timeout
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    state_t state, state_nxt;
    logic [2:0] last, sel_idx;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [NREQ-1:0] arb_gnt, own_mask;
    logic [SRCW-1:0] sel_src;
    logic [DSTW-1:0] sel_dst;
    logic sel_lock, gnt, src_ok, tmo;

    rr_arbiter #(.NREQ(NREQ)) u_arb (.req(req_valid), .last(last), .grant(arb_gnt));

    // While locked only the owner can win, so ready never depends on codes.
    assign own_mask  = NREQ'(1) << owner;
    assign req_ready = (state == IDLE) ? arb_gnt : (req_valid & own_mask);
    assign locked    = (state == LOCKED);

    always_comb begin
        sel_src = '0;
        sel_dst = '0;
        sel_lock = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_src = req_src[i*SRCW +: SRCW];
                sel_dst = req_dst[i*DSTW +: DSTW];
                sel_lock = req_lock[i];
                sel_idx = 3'(i);
            end
        end
        gnt = |req_ready;
        src_ok = 32'(sel_src) < NSRC;
        tmo = (state == LOCKED) && gnt && sel_lock && (cnt == CW'(LOCK_MAX - 1));
        state_nxt = (gnt && sel_lock && !tmo) ? LOCKED : IDLE;
        cnt_nxt = (state_nxt == IDLE) ? '0 : (state == IDLE) ? CW'(1) : cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            cnt <= '0;
            last <= 3'(NREQ - 1);
            owner <= '0;
            src_oe <= '0;
            dst_code <= '0;
            dst_valid <= 1'b0;
            err_src <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            lock_timeout <= tmo;
            src_oe <= (gnt && src_ok) ? (NSRC'(1) << sel_src) : '0;
            dst_valid <= gnt && src_ok;
            err_src <= gnt && !src_ok;
            if (gnt) begin
                last <= sel_idx;
                owner <= sel_idx;
                dst_code <= sel_dst;
            end
        end
    end
endmodule

// File: tb/tb_bus_scheduler.sv
// tb_bus_scheduler: directed checks of arbitration, locking, timeout, illegal
// sources and asynchronous reset with hand-computed expectations.
module tb_bus_scheduler;
    logic        clk = 1'b0;
    logic        clr_n;
    logic [3:0]  req_valid, req_lock, req_ready;
    logic [19:0] req_src, req_dst;
    logic [24:0] src_oe;
    logic [4:0]  dst_code;
    logic        dst_valid, locked, err_src, lock_timeout;
    logic [2:0]  owner;
    int tests = 0;
    int fails = 0;

    bus_scheduler dut (
        .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_src(req_src),
        .req_dst(req_dst), .req_lock(req_lock), .req_ready(req_ready),
        .src_oe(src_oe), .dst_code(dst_code), .dst_valid(dst_valid),
        .owner(owner), .locked(locked), .err_src(err_src), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        clr_n = 1'b0;
        req_valid = '0;
        req_lock = '0;
        req_src = '0;
        req_dst = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_oe", 32'(src_oe), 0);
        chk("rst_dst", 32'(dst_code), 0);
        chk("rst_dv", 32'(dst_valid), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err_src), 0);
        chk("rst_tmo", 32'(lock_timeout), 0);
        clr_n = 1'b1;

        req_valid = 4'b0001;
        req_dst = {5'd0, 5'd0, 5'd0, 5'd3};
        #1 chk("t1_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("t1_oe", 32'(src_oe), 32'h1);
        chk("t1_dst", 32'(dst_code), 3);
        chk("t1_dv", 32'(dst_valid), 1);
        chk("t1_owner", 32'(owner), 0);

        // last is now 0, so the rotation starts at requester 1
        req_valid = 4'b1111;
        req_src = {5'd5, 5'd4, 5'd3, 5'd2};
        req_dst = {5'd13, 5'd12, 5'd11, 5'd10};
        for (int k = 0; k < 8; k++) begin
            idx = (k + 1) % 4;
            #1 chk("rr_ready", 32'(req_ready), 32'(1) << idx);
            tick();
            chk("rr_oe", 32'(src_oe), 32'(1) << (2 + idx));
            chk("rr_owner", 32'(owner), 32'(idx));
            chk("rr_dst", 32'(dst_code), 32'(10 + idx));
        end

        req_valid = 4'b0111;
        req_lock = 4'b0010;
        req_src = {5'd0, 5'd4, 5'd19, 5'd2};
        for (int g = 1; g <= 4; g++) begin
            if (g == 4) req_lock = 4'b0000;
            #1 chk("lk_ready", 32'(req_ready), 32'b0010);
            tick();
            chk("lk_owner", 32'(owner), 1);
            chk("lk_locked", 32'(locked), (g < 4) ? 1 : 0);
            chk("lk_oe", 32'(src_oe), 32'(1) << 19);
        end
        #1 chk("lk_next_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("lk_next_owner", 32'(owner), 2);
        req_valid = '0;
        tick();
        chk("idle_dv", 32'(dst_valid), 0);
        chk("idle_oe", 32'(src_oe), 0);

        req_valid = 4'b1001;
        req_lock = 4'b1000;
        req_src = {5'd23, 5'd0, 5'd0, 5'd1};
        for (int g = 1; g <= 8; g++) begin
            #1 chk("to_ready", 32'(req_ready), 32'b1000);
            tick();
            chk("to_pulse", 32'(lock_timeout), (g == 8) ? 1 : 0);
            chk("to_locked", 32'(locked), (g < 8) ? 1 : 0);
            chk("to_oe", 32'(src_oe), 32'(1) << 23);
        end
        #1 chk("to_next_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("to_next_owner", 32'(owner), 0);
        chk("to_pulse_end", 32'(lock_timeout), 0);
        chk("to_next_oe", 32'(src_oe), 32'h2);

        req_valid = 4'b0100;
        req_lock = '0;
        req_src = {5'd0, 5'd27, 5'd0, 5'd0};
        #1 chk("ill_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("ill_oe", 32'(src_oe), 0);
        chk("ill_dv", 32'(dst_valid), 0);
        chk("ill_err", 32'(err_src), 1);
        req_valid = '0;
        tick();
        chk("ill_err_end", 32'(err_src), 0);

        req_valid = 4'b0010;
        req_lock = 4'b0010;
        req_src = {5'd0, 5'd0, 5'd2, 5'd18};
        #1 chk("rl_ready", 32'(req_ready), 32'b0010);
        tick();
        chk("rl_locked", 32'(locked), 1);
        chk("rl_owner", 32'(owner), 1);
        #1 chk("rl_ready2", 32'(req_ready), 32'b0010);
        tick();
        chk("rl_locked2", 32'(locked), 1);
        clr_n = 1'b0;
        #1;
        chk("rl_oe", 32'(src_oe), 0);
        chk("rl_locked0", 32'(locked), 0);
        chk("rl_owner0", 32'(owner), 0);
        chk("rl_dv", 32'(dst_valid), 0);
        chk("rl_dst", 32'(dst_code), 0);
        req_valid = 4'b0011;
        req_lock = '0;
        tick();
        clr_n = 1'b1;
        #1 chk("rl_post_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("rl_post_owner", 32'(owner), 0);
        chk("rl_post_oe", 32'(src_oe), 32'(1) << 18);
        chk("rl_post_dv", 32'(dst_valid), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
